// File: rtl/fifo_test_sequencer_pkg.sv
// Shared state encoding, FIFO-test mode codes and LFSR helper for the FIFO test sequencer.
package fifo_test_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SETTLE,
        ST_RUN,
        ST_DONE
    } seq_state_t;

    localparam logic [1:0]  MODE_IDLE = 2'b00;
    localparam logic [1:0]  MODE_WR   = 2'b01;
    localparam logic [1:0]  MODE_RW   = 2'b11;

    // Galois form of x^16 + x^14 + x^13 + x^11, shifting right.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/fifo_test_sequencer_if.sv
// Control and status bundle between the sequencer (master) and the dual-clock FIFO test (slave).
interface fifo_test_sequencer_if;

    logic [1:0] mode;
    logic       fifo_aclr;
    logic       any_mismatch;
    logic       rd_empty;
    logic       wr_full;

    modport master (
        output mode, fifo_aclr,
        input  any_mismatch, rd_empty, wr_full
    );

    modport slave (
        input  mode, fifo_aclr,
        output any_mismatch, rd_empty, wr_full
    );

endinterface

// File: rtl/fifo_test_sequencer_status_sync.sv
// Two-flop synchroniser for status bits arriving from the FIFO clock domains.
module status_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_test_sequencer.sv
// Sequencer driving mode/fifo_aclr of the dual-clock FIFO test through a fixed, LFSR-jittered schedule.
//   state  | meaning
//   IDLE   | FIFO held in clear, waiting for start
//   CLR    | fifo_aclr high for CLR_CYCLES
//   SETTLE | clear released, mode idle, lets synchronisers flush
//   RUN    | soak phases: even/final = read+write, odd = write-only
//   DONE   | schedule complete, pass valid
module fifo_test_sequencer
    import fifo_test_sequencer_pkg::*;
#(
    parameter int          DWELL_W       = 24,
    parameter int          BASE_DWELL    = 10000000,
    parameter int          NUM_TOGGLES   = 16,
    parameter int          CLR_CYCLES    = 16,
    parameter int          SETTLE_CYCLES = 16,
    parameter int          STALL_CYCLES  = 65535,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         aclr_n,
    input  logic                         start,
    input  logic                         abort,
    fifo_test_sequencer_if.master        bus,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         err_mismatch,
    output logic                         err_stall,
    output logic                         err_nofill,
    output logic [7:0]                   phase
);

    localparam int                 STALL_W     = $clog2(STALL_CYCLES + 1);
    localparam logic [7:0]         LAST_TOGGLE = 8'(2 * NUM_TOGGLES);
    localparam logic [7:0]         FINAL_PHASE = 8'(2 * NUM_TOGGLES + 1);
    localparam logic [DWELL_W-1:0] BASE_D      = DWELL_W'(BASE_DWELL);
    localparam logic [DWELL_W-1:0] CLR_LOAD    = DWELL_W'(CLR_CYCLES - 1);
    localparam logic [DWELL_W-1:0] SETTLE_LOAD = DWELL_W'(SETTLE_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_MAX   = STALL_W'(STALL_CYCLES);
    localparam logic [STALL_W-1:0] STALL_LAST  = STALL_W'(STALL_CYCLES - 1);

    if (64'(BASE_DWELL) + 64'd15 >= (64'd1 << DWELL_W)) begin : g_bad_dwell
        $error("BASE_DWELL + 15 does not fit in DWELL_W bits");
    end
    if (CLR_CYCLES < 1 || SETTLE_CYCLES < 3) begin : g_bad_timing
        $error("CLR_CYCLES must be >= 1 and SETTLE_CYCLES >= 3");
    end

    seq_state_t         state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_load;
    logic [STALL_W-1:0] stall_cnt;
    logic [15:0]        lfsr;
    logic               reclr;
    logic               full_seen;
    logic [2:0]         status_s;
    logic               mismatch_s, rd_empty_s, wr_full_s;
    logic               in_run, wr_phase, cnt_zero;
    logic               mm_evt, stall_evt, nofill_evt;

    status_sync #(.WIDTH(3)) u_status_sync (
        .clk    (clk),
        .aclr_n (aclr_n),
        .d      ({bus.any_mismatch, bus.rd_empty, bus.wr_full}),
        .q      (status_s)
    );

    assign mismatch_s = status_s[2];
    assign rd_empty_s = status_s[1];
    assign wr_full_s  = status_s[0];

    assign in_run     = (state == ST_RUN);
    assign wr_phase   = phase[0] && (phase != FINAL_PHASE);
    assign cnt_zero   = (cnt == '0);
    assign dwell_load = BASE_D + DWELL_W'(lfsr[3:0]);

    // Events on the last cycle of a phase still count, including into pass.
    assign mm_evt     = in_run && mismatch_s;
    assign stall_evt  = in_run && !wr_phase && rd_empty_s && (stall_cnt == STALL_LAST);
    assign nofill_evt = in_run && wr_phase && cnt_zero && !full_seen && !wr_full_s;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state         <= ST_IDLE;
            bus.mode      <= MODE_IDLE;
            bus.fifo_aclr <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_mismatch  <= 1'b0;
            err_stall     <= 1'b0;
            err_nofill    <= 1'b0;
            phase         <= '0;
            lfsr          <= LFSR_SEED;
            cnt           <= '0;
            stall_cnt     <= '0;
            reclr         <= 1'b0;
            full_seen     <= 1'b0;
        end else begin
            err_mismatch <= err_mismatch | mm_evt;
            err_stall    <= err_stall | stall_evt;
            err_nofill   <= err_nofill | nofill_evt;

            if (in_run) begin
                if (wr_phase)
                    full_seen <= full_seen | wr_full_s;
                else if (!rd_empty_s)
                    stall_cnt <= '0;
                else if (stall_cnt != STALL_MAX)
                    stall_cnt <= stall_cnt + 1'b1;
            end

            if (abort) begin
                state         <= ST_IDLE;
                bus.mode      <= MODE_IDLE;
                bus.fifo_aclr <= 1'b1;
                busy          <= 1'b0;
                done          <= 1'b0;
                pass          <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            err_mismatch  <= 1'b0;
                            err_stall     <= 1'b0;
                            err_nofill    <= 1'b0;
                            phase         <= '0;
                            lfsr          <= LFSR_SEED;
                            reclr         <= 1'b0;
                            state         <= ST_CLR;
                            cnt           <= CLR_LOAD;
                            bus.fifo_aclr <= 1'b1;
                            bus.mode      <= MODE_IDLE;
                            busy          <= 1'b1;
                            done          <= 1'b0;
                            pass          <= 1'b0;
                        end
                    end
                    ST_CLR: begin
                        if (cnt_zero) begin
                            state         <= ST_SETTLE;
                            cnt           <= SETTLE_LOAD;
                            bus.fifo_aclr <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_zero) begin
                            state     <= ST_RUN;
                            cnt       <= dwell_load;
                            lfsr      <= lfsr_step(lfsr);
                            bus.mode  <= MODE_RW;
                            stall_cnt <= '0;
                            full_seen <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!cnt_zero) begin
                            cnt <= cnt - 1'b1;
                        end else if (phase < LAST_TOGGLE) begin
                            phase     <= phase + 1'b1;
                            cnt       <= dwell_load;
                            lfsr      <= lfsr_step(lfsr);
                            bus.mode  <= phase[0] ? MODE_RW : MODE_WR;
                            stall_cnt <= '0;
                            full_seen <= 1'b0;
                        end else if (!reclr) begin
                            reclr         <= 1'b1;
                            phase         <= phase + 1'b1;
                            state         <= ST_CLR;
                            cnt           <= CLR_LOAD;
                            bus.fifo_aclr <= 1'b1;
                            bus.mode      <= MODE_IDLE;
                        end else begin
                            state    <= ST_DONE;
                            bus.mode <= MODE_IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= !(err_mismatch | mm_evt | err_stall | stall_evt
                                          | err_nofill | nofill_evt);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
